// File: rtl/param_prio_arbiter.sv
// Priority arbiter with rotating tie-break, aging boost for starved requesters,
// and an optional hold that lets the current owner keep the grant.
module param_prio_arbiter #(
  parameter int N         = 4,
  parameter int PW        = 3,
  parameter int AGE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*PW-1:0]      prios,
  input  logic                 hold,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 valid,
  output logic [N-1:0]         starve
);

  localparam int IW = $clog2(N);
  localparam int AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;
  localparam int EW = PW + 1;

  logic [AW-1:0] age [N];
  logic [IW-1:0] ptr;

  logic [N-1:0]  boost;
  logic [EW-1:0] eff [N];
  logic [EW-1:0] max_eff;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_sum;
  logic          keep;
  logic [N-1:0]  gnt_next;

  // Boost is the MSB of the effective priority, so a starved requester beats
  // any unboosted one and boosted ties fall back to the rotating pointer.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      boost[i] = (AGE_LIMIT != 0) && (age[i] == AW'(AGE_LIMIT));
      eff[i]   = {boost[i], prios[i*PW +: PW]};
    end
  end

  always_comb begin
    max_eff = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (eff[i] > max_eff)) max_eff = eff[i];
    end
  end

  // First candidate at or after ptr, wrapping N-1 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, ptr} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) scan_sum = scan_sum - (IW+1)'(N);
      if (!win_found && req[scan_sum[IW-1:0]] && (eff[scan_sum[IW-1:0]] == max_eff)) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    keep     = hold && |(gnt & req);
    gnt_next = '0;
    if (keep)           gnt_next = gnt;
    else if (win_found) gnt_next = N'(1) << win_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= '0;
      for (int i = 0; i < N; i++) age[i] <= '0;
    end else begin
      gnt <= gnt_next;
      if (!keep && win_found) begin
        gnt_idx <= win_idx;
        ptr     <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (gnt_next[i] || !req[i])        age[i] <= '0;
        else if (age[i] != AW'(AGE_LIMIT)) age[i] <= age[i] + 1'b1;
      end
    end
  end

  assign valid  = |gnt;
  assign starve = boost;

endmodule

// File: tb/tb_param_prio_arbiter.sv
// Randomized bench for param_prio_arbiter: directed scenarios with constant
// expectations, then random traffic compared against an index-level model.
module tb_param_prio_arbiter;

  localparam int N         = 4;
  localparam int PW        = 3;
  localparam int AGE_LIMIT = 4;
  localparam int IW        = $clog2(N);

  logic              clk;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*PW-1:0]   prios;
  logic              hold;
  logic [N-1:0]      gnt;
  logic [IW-1:0]     gnt_idx;
  logic              valid;
  logic [N-1:0]      starve;

  int checks;
  int errors;

  // Reference model state: owner index (-1 = none), last index, pointer, waits.
  int m_cur;
  int m_idx;
  int m_ptr;
  int m_age [N];

  param_prio_arbiter #(.N(N), .PW(PW), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .rst(rst), .req(req), .prios(prios), .hold(hold),
    .gnt(gnt), .gnt_idx(gnt_idx), .valid(valid), .starve(starve)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_of(input int i);
    int e;
    e = int'(prios[i*PW +: PW]);
    if (AGE_LIMIT != 0 && m_age[i] == AGE_LIMIT) e += (1 << PW);
    return e;
  endfunction

  task automatic model_reset();
    m_cur = -1;
    m_idx = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_step();
    int nxt;
    int best;
    int j;
    bit held;
    nxt  = -1;
    held = 0;
    if (hold && m_cur >= 0 && req[m_cur]) begin
      nxt  = m_cur;
      held = 1;
    end else begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (req[i] && eff_of(i) > best) best = eff_of(i);
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (nxt < 0 && req[j] && eff_of(j) == best) nxt = j;
      end
      if (nxt >= 0) begin
        m_idx = nxt;
        m_ptr = (nxt + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == nxt)     m_age[i] = 0;
      else if (req[i])  m_age[i] = (m_age[i] < AGE_LIMIT) ? m_age[i] + 1 : AGE_LIMIT;
      else              m_age[i] = 0;
    end
    m_cur = nxt;
  endtask

  task automatic model_compare();
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_starve;
    exp_gnt    = (m_cur >= 0) ? N'(1) << m_cur : '0;
    exp_starve = '0;
    for (int i = 0; i < N; i++)
      if (AGE_LIMIT != 0 && m_age[i] == AGE_LIMIT) exp_starve[i] = 1'b1;
    check("m_gnt", 32'(gnt), 32'(exp_gnt));
    if (m_cur >= 0 || m_idx != 0) check("m_idx", 32'(gnt_idx), 32'(m_idx));
    check("m_valid", 32'(valid), 32'(m_cur >= 0));
    check("m_starve", 32'(starve), 32'(exp_starve));
  endtask

  // ---------------- drivers ----------------
  task automatic set_prio(input int i, input int v);
    prios[i*PW +: PW] = PW'(v);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_compare();
  endtask

  task automatic do_reset();
    req   = '0;
    hold  = 1'b0;
    prios = '0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  // Reset asserted between edges must clear outputs before the next edge.
  task automatic async_reset_check();
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_starve", 32'(starve), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0;
    hold   = 1'b0;
    prios  = '0;
    model_reset();
    #1;
    check("por_gnt", 32'(gnt), 32'd0);
    do_reset();

    // Async reset while gnt=0100, then first grant restarts from ptr=0.
    req = 4'b0100;
    tick();
    check("ar_pre", 32'(gnt), 32'b0100);
    async_reset_check();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_prio(i, 4);
    tick();
    check("ar_post", 32'(gnt), 32'b0001);

    // Priority selection.
    do_reset();
    req = 4'b0111;
    set_prio(0, 2); set_prio(1, 5); set_prio(2, 3); set_prio(3, 0);
    tick();
    check("prio_gnt", 32'(gnt), 32'b0010);
    check("prio_idx", 32'(gnt_idx), 32'd1);
    check("prio_valid", 32'(valid), 32'd1);

    // Rotation among equal priorities.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_prio(i, 4);
    begin
      logic [3:0] rot_exp [5];
      rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int s = 0; s < 5; s++) begin
        tick();
        check($sformatf("rot%0d", s), 32'(gnt), 32'(rot_exp[s]));
      end
    end

    // Aging boost of a low-priority waiter.
    do_reset();
    req = 4'b0011;
    set_prio(0, 7); set_prio(1, 1);
    for (int s = 1; s <= 4; s++) begin
      tick();
      check($sformatf("age_gnt%0d", s), 32'(gnt), 32'b0001);
    end
    check("age_starve", 32'(starve[1]), 32'd1);
    tick();
    check("age_boost", 32'(gnt), 32'b0010);
    check("age_clear", 32'(starve), 32'd0);
    tick();
    check("age_back", 32'(gnt), 32'b0001);

    // Hold retains grant against a higher priority; releasing re-arbitrates.
    do_reset();
    req = 4'b0100;
    set_prio(2, 1);
    tick();
    check("hold_pre", 32'(gnt), 32'b0100);
    hold = 1'b1;
    req  = 4'b0101;
    set_prio(0, 7);
    tick();
    check("hold_keep0", 32'(gnt), 32'b0100);
    tick();
    check("hold_keep1", 32'(gnt), 32'b0100);
    hold = 1'b0;
    tick();
    check("hold_rel", 32'(gnt), 32'b0001);

    // Pointer wrap after granting index 3, then idle holds gnt_idx.
    do_reset();
    for (int i = 0; i < N; i++) set_prio(i, 2);
    req = 4'b1000;
    tick();
    check("wrap_g3", 32'(gnt_idx), 32'd3);
    req = 4'b0101;
    tick();
    check("wrap_a", 32'(gnt), 32'b0001);
    tick();
    check("wrap_b", 32'(gnt), 32'b0100);
    req = 4'b0000;
    tick();
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_idx", 32'(gnt_idx), 32'd2);

    // Random traffic with occasional mid-run async resets.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) != 0) req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) set_prio($urandom_range(0, N - 1), $urandom_range(0, 3));
      hold = ($urandom_range(0, 2) == 0);
      tick();
      if (c % 400 == 399) async_reset_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_prio_arbiter.md
PARAM_PRIO_ARBITER -- requirements
Module: param_prio_arbiter

Interface
REQ-001 Parameter N, default 4, SHALL set the number of requesters (legal range 2..16).
REQ-002 Parameter PW, default 3, SHALL set the priority field width per requester.
REQ-003 Parameter AGE_LIMIT, default 8, SHALL set the wait count that boosts a requester (0 disables aging).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 req  input  N  SHALL carry the request bits, one per requester.
REQ-007 prios  input  N*PW  SHALL carry the priorities; requester i uses prios[i*PW +: PW]; larger value means higher priority.
REQ-008 hold  input  1  SHALL request that the current grant be retained.
REQ-009 gnt  output  N  SHALL be the registered grant vector: one-hot or all-zero.
REQ-010 gnt_idx  output  clog2(N)  SHALL be the registered index of the granted requester.
REQ-011 valid  output  1  SHALL equal |gnt.
REQ-012 starve  output  N  SHALL flag per requester age_i == AGE_LIMIT (all-zero when AGE_LIMIT=0).

Function
REQ-013 Per requester i: boost_i = (AGE_LIMIT!=0 && age_i==AGE_LIMIT); effective priority eff_i = {boost_i, prio_i} (PW+1 bits).
REQ-014 Candidate set SHALL be the requesters with req_i=1 whose eff_i equals the maximum eff over all asserted requests.
REQ-015 Winner SHALL be the first candidate found scanning upward from rotating pointer ptr, wrapping N-1 -> 0.
REQ-016 Grant latency SHALL be one cycle: inputs sampled at edge k produce gnt/gnt_idx after edge k.
REQ-017 On a new grant to index w, ptr SHALL update to (w+1) mod N.
REQ-018 With req=0, gnt SHALL become 0 on the next edge; ptr and gnt_idx SHALL hold.
REQ-019 Hold: if hold=1, gnt[k]=1 and req[k]=1, gnt, gnt_idx and ptr SHALL hold regardless of priority or boost.
REQ-020 If hold=1 but the holder has deasserted req, normal arbitration SHALL apply at that same edge.
REQ-021 Age counters SHALL be clog2(AGE_LIMIT+1) bits wide, saturating at AGE_LIMIT.
REQ-022 At each edge, age_i SHALL: clear to 0 if i is granted after the edge; else increment (saturating) if req_i=1; else clear to 0.
REQ-023 A held grant SHALL keep age of the holder at 0; other waiting requesters SHALL continue aging.
REQ-024 With two or more boosted candidates, ties SHALL resolve by ptr exactly as for unboosted ties.
REQ-025 gnt SHALL never have more than one bit set, and SHALL never grant a requester whose req was 0 at the sampling edge.

Reset
REQ-026 rst=1 SHALL, without waiting for a clock edge, force gnt=0, gnt_idx=0, valid=0, ptr=0, all ages=0 and starve=0.
REQ-027 Deasserting rst mid-operation SHALL resume arbitration from the reset state; the first grant is possible at the first edge after release.

Verification (N=4, PW=3, AGE_LIMIT=4)
REQ-028 Async reset: assert rst between edges while gnt=0100 -> gnt=0, valid=0 immediately; ptr=0 after release.
REQ-029 Priority: req=0111, p0=2, p1=5, p2=3 -> after next edge gnt=0010, gnt_idx=1, valid=1.
REQ-030 Rotation: req=1111, all prios=4, hold=0 -> successive gnt 0001, 0010, 0100, 1000, 0001.
REQ-031 Aging: req=0011, p0=7, p1=1 held constant ->
- gnt=0001 for four edges;
- starve[1]=1 after edge 4;
- gnt=0010 after edge 5, with age1 cleared;
- gnt=0001 after edge 6.
REQ-032 Hold: gnt=0100 with hold=1 and req2 held; raise req0 with p0=7 -> gnt stays 0100. Then drop hold -> gnt=0001 after the next edge.
REQ-033 Wrap: after a grant to index 3 (ptr=0), req=0101 with equal prios -> gnt=0001. Next tie with req=0101 -> gnt=0100.
